// File: rtl/cpu_phase_pkg.sv
// Shared definitions for the instruction phase sequencer: one-hot state
// encoding, phase bit positions and the default fetch-wait budget.
package cpu_phase_pkg;

    localparam int NUM_STATES       = 11;
    localparam int FW_IDX           = 0;
    localparam int P1_IDX           = 1;
    localparam int P2_IDX           = 2;
    localparam int P3_IDX           = 3;
    localparam int P4_IDX           = 4;
    localparam int P5_IDX           = 5;
    localparam int P6_IDX           = 6;
    localparam int P7_IDX           = 7;
    localparam int P8_IDX           = 8;
    localparam int PAUSE_IDX        = 9;
    localparam int HALT_IDX         = 10;
    localparam int DEFAULT_WAIT_MAX = 15;

    typedef enum logic [NUM_STATES-1:0] {
        ST_FETCH_WAIT = 11'b000_0000_0001 << FW_IDX,
        ST_P1         = 11'b000_0000_0001 << P1_IDX,
        ST_P2         = 11'b000_0000_0001 << P2_IDX,
        ST_P3         = 11'b000_0000_0001 << P3_IDX,
        ST_P4         = 11'b000_0000_0001 << P4_IDX,
        ST_P5         = 11'b000_0000_0001 << P5_IDX,
        ST_P6         = 11'b000_0000_0001 << P6_IDX,
        ST_P7         = 11'b000_0000_0001 << P7_IDX,
        ST_P8         = 11'b000_0000_0001 << P8_IDX,
        ST_PAUSE      = 11'b000_0000_0001 << PAUSE_IDX,
        ST_HALT       = 11'b000_0000_0001 << HALT_IDX
    } state_t;

    // True when the state is one of the eight strobe-issuing phases.
    function automatic logic is_phase(input state_t s);
        logic [NUM_STATES-1:0] v;
        v = s;
        return |v[P8_IDX:P1_IDX];
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts cycles spent waiting on instruction memory; flags expiry when the
// count reaches WAIT_MAX-1 so the sequencer can declare a fetch timeout.
module fetch_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    logic [CW-1:0] r_cnt;

    // Wait counter: clear has priority over count enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_en) begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = (r_cnt == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase controller: steps through fetch-wait and eight one-hot
// phase strobes, skipping P5/P6 for single-operation instructions, with
// halt, single-step and fault stop. Strobes come straight from state flops.
module phase_sequencer
    import cpu_phase_pkg::*;
#(
    parameter int WAIT_MAX = DEFAULT_WAIT_MAX,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_ready,
    input  logic [3:0]       num_of_ope,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    output logic             clock_1,
    output logic             clock_2,
    output logic             clock_3,
    output logic             clock_4,
    output logic             clock_5,
    output logic             clock_6,
    output logic             clock_7,
    output logic             clock_8,
    output logic             busy,
    output logic             halted,
    output logic             timeout_err,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_ope_len;
    logic             r_halt_pending;
    logic             r_timeout_err;
    logic             r_illegal_op;
    logic             r_busy;
    logic             r_step_used;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_halt;
    logic             w_step_ok;
    logic             w_set_timeout;
    logic             w_set_illegal;
    logic             w_step_exit;
    logic             w_expired;

    fetch_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_fetch_wait_timer (
        .clk       (clk),
        .rst_n     (reset),
        .i_clr     (w_next_state != ST_FETCH_WAIT),
        .i_en      ((r_state == ST_FETCH_WAIT) && !fetch_ready),
        .o_expired (w_expired)
    );

    // Next-state logic; a halt request seen this cycle counts as pending.
    always_comb begin
        w_next_state  = r_state;
        w_set_timeout = 1'b0;
        w_set_illegal = 1'b0;
        w_step_exit   = 1'b0;
        w_halt        = r_halt_pending | halt_req;
        w_step_ok     = step & ~r_step_used;
        case (r_state)
            ST_FETCH_WAIT: begin
                if (w_halt) begin
                    w_next_state = ST_HALT;
                end else if (fetch_ready) begin
                    w_next_state = ST_P1;
                end else if (w_expired) begin
                    w_next_state  = ST_HALT;
                    w_set_timeout = 1'b1;
                end else begin
                    w_next_state = ST_FETCH_WAIT;
                end
            end
            ST_P1: w_next_state = ST_P2;
            ST_P2: w_next_state = ST_P3;
            ST_P3: begin
                if (num_of_ope == 4'd0) begin
                    w_next_state  = ST_HALT;
                    w_set_illegal = 1'b1;
                end else begin
                    w_next_state = ST_P4;
                end
            end
            ST_P4: begin
                if (r_ope_len == 4'd1) begin
                    w_next_state = ST_P7;
                end else begin
                    w_next_state = ST_P5;
                end
            end
            ST_P5: w_next_state = ST_P6;
            ST_P6: w_next_state = ST_P7;
            ST_P7: w_next_state = ST_P8;
            ST_P8: begin
                if (w_halt) begin
                    w_next_state = ST_HALT;
                end else if (!run) begin
                    w_next_state = ST_PAUSE;
                end else begin
                    w_next_state = ST_FETCH_WAIT;
                end
            end
            ST_PAUSE: begin
                if (w_halt) begin
                    w_next_state = ST_HALT;
                end else if (run) begin
                    w_next_state = ST_FETCH_WAIT;
                end else if (w_step_ok) begin
                    w_next_state = ST_FETCH_WAIT;
                    w_step_exit  = 1'b1;
                end else begin
                    w_next_state = ST_PAUSE;
                end
            end
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_HALT;
        endcase
    end

    // State register plus sticky flags, operand length and retire counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_FETCH_WAIT;
            r_ope_len      <= 4'd0;
            r_halt_pending <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_illegal_op   <= 1'b0;
            r_busy         <= 1'b0;
            r_step_used    <= 1'b0;
            r_instr_count  <= {CNT_W{1'b0}};
        end else begin
            r_state        <= w_next_state;
            r_ope_len      <= (r_state == ST_P3) ? num_of_ope : r_ope_len;
            r_halt_pending <= r_halt_pending | halt_req;
            r_timeout_err  <= r_timeout_err | w_set_timeout;
            r_illegal_op   <= r_illegal_op | w_set_illegal;
            r_busy         <= is_phase(w_next_state);
            // A held step only advances once; it must drop before re-arming.
            r_step_used    <= step & (r_step_used | w_step_exit);
            if (r_state == ST_P8) begin
                r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_instr_count <= r_instr_count;
            end
        end
    end

    assign clock_1     = r_state[P1_IDX];
    assign clock_2     = r_state[P2_IDX];
    assign clock_3     = r_state[P3_IDX];
    assign clock_4     = r_state[P4_IDX];
    assign clock_5     = r_state[P5_IDX];
    assign clock_6     = r_state[P6_IDX];
    assign clock_7     = r_state[P7_IDX];
    assign clock_8     = r_state[P8_IDX];
    assign busy        = r_busy;
    assign halted      = r_state[HALT_IDX];
    assign timeout_err = r_timeout_err;
    assign illegal_op  = r_illegal_op;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: strobe order, 1-op skip, fetch wait,
// pause/step, halt, timeout, reset mid-instruction and illegal opcode.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_ready;
    logic [3:0]  num_of_ope;
    logic        run;
    logic        step;
    logic        halt_req;
    logic        clock_1, clock_2, clock_3, clock_4;
    logic        clock_5, clock_6, clock_7, clock_8;
    logic        busy;
    logic        halted;
    logic        timeout_err;
    logic        illegal_op;
    logic [31:0] instr_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] one = 8'h01;
    logic [7:0] pat1 [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h40, 8'h80, 8'h00};

    phase_sequencer #(
        .WAIT_MAX (15),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_ready (fetch_ready),
        .num_of_ope  (num_of_ope),
        .run         (run),
        .step        (step),
        .halt_req    (halt_req),
        .clock_1     (clock_1),
        .clock_2     (clock_2),
        .clock_3     (clock_3),
        .clock_4     (clock_4),
        .clock_5     (clock_5),
        .clock_6     (clock_6),
        .clock_7     (clock_7),
        .clock_8     (clock_8),
        .busy        (busy),
        .halted      (halted),
        .timeout_err (timeout_err),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    function automatic logic [7:0] strobes();
        return {clock_8, clock_7, clock_6, clock_5, clock_4, clock_3, clock_2, clock_1};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus and checks.
    initial begin
        reset       = 1'b0;
        fetch_ready = 1'b1;
        num_of_ope  = 4'd2;
        run         = 1'b1;
        step        = 1'b0;
        halt_req    = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_strobes", 32'(strobes()), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_halted", 32'(halted), 32'h0);
        check_val("rst_timeout", 32'(timeout_err), 32'h0);
        check_val("rst_illegal", 32'(illegal_op), 32'h0);
        check_val("rst_count", instr_count, 32'h0);

        // Two-op instructions, 9-cycle period.
        reset = 1'b1;
        for (int k = 0; k < 27; k++) begin
            tick();
            check_val("op2_strobe", 32'(strobes()), ((k % 9) < 8) ? 32'(one << (k % 9)) : 32'h0);
            check_val("op2_busy", 32'(busy), ((k % 9) < 8) ? 32'h1 : 32'h0);
        end
        check_val("op2_count", instr_count, 32'd3);

        // One-op instructions skip P5/P6, 7-cycle period.
        num_of_ope = 4'd1;
        for (int k = 0; k < 14; k++) begin
            tick();
            check_val("op1_strobe", 32'(strobes()), 32'(pat1[k % 7]));
        end
        check_val("op1_count", instr_count, 32'd5);

        // Fetch stall for 5 cycles, then P1.
        fetch_ready = 1'b0;
        repeat (5) begin
            tick();
            check_val("stall_strobe", 32'(strobes()), 32'h0);
            check_val("stall_halted", 32'(halted), 32'h0);
        end
        fetch_ready = 1'b1;
        tick();
        check_val("stall_p1", 32'(strobes()), 32'h01);

        // run=0: finish the instruction, then park in PAUSE.
        run        = 1'b0;
        num_of_ope = 4'd2;
        for (int k = 1; k < 8; k++) begin
            tick();
            check_val("run0_strobe", 32'(strobes()), 32'(one << k));
        end
        repeat (4) begin
            tick();
            check_val("pause_strobe", 32'(strobes()), 32'h0);
            check_val("pause_busy", 32'(busy), 32'h0);
        end
        check_val("pause_count", instr_count, 32'd6);

        // 3-cycle step pulse: exactly one instruction.
        step = 1'b1;
        tick();
        check_val("step_fw", 32'(strobes()), 32'h0);
        tick();
        check_val("step_p1", 32'(strobes()), 32'h01);
        tick();
        check_val("step_p2", 32'(strobes()), 32'h02);
        step = 1'b0;
        for (int k = 2; k < 8; k++) begin
            tick();
            check_val("step_strobe", 32'(strobes()), 32'(one << k));
        end
        repeat (3) begin
            tick();
            check_val("step_pause", 32'(strobes()), 32'h0);
        end
        check_val("step_count", instr_count, 32'd7);

        // Halt pulsed in P3: instruction completes, then HALT.
        run = 1'b1;
        tick();
        check_val("halt_fw", 32'(strobes()), 32'h0);
        tick();
        tick();
        tick();
        check_val("halt_p3", 32'(strobes()), 32'h04);
        halt_req = 1'b1;
        tick();
        check_val("halt_p4", 32'(strobes()), 32'h08);
        halt_req = 1'b0;
        for (int k = 4; k < 8; k++) begin
            tick();
            check_val("halt_strobe", 32'(strobes()), 32'(one << k));
        end
        repeat (3) begin
            tick();
            check_val("halt_halted", 32'(halted), 32'h1);
            check_val("halt_strobe0", 32'(strobes()), 32'h0);
            check_val("halt_busy", 32'(busy), 32'h0);
            check_val("halt_count", instr_count, 32'd8);
        end

        // Fetch timeout after 15 cycles of no ready.
        reset       = 1'b0;
        fetch_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst2_halted", 32'(halted), 32'h0);
        check_val("rst2_count", instr_count, 32'h0);
        reset = 1'b1;
        repeat (14) begin
            tick();
            check_val("to_strobe", 32'(strobes()), 32'h0);
            check_val("to_wait", 32'(halted), 32'h0);
        end
        tick();
        check_val("to_halted", 32'(halted), 32'h1);
        check_val("to_err", 32'(timeout_err), 32'h1);

        // Reset asserted in P5 clears everything at once.
        reset       = 1'b0;
        fetch_ready = 1'b1;
        num_of_ope  = 4'd2;
        repeat (2) @(negedge clk);
        check_val("rst3_timeout", 32'(timeout_err), 32'h0);
        check_val("rst3_halted", 32'(halted), 32'h0);
        reset = 1'b1;
        repeat (9) tick();
        check_val("mid_count1", instr_count, 32'd1);
        repeat (5) tick();
        check_val("mid_p5", 32'(strobes()), 32'h10);
        #1 reset = 1'b0;
        #1;
        check_val("mid_rst_strobe", 32'(strobes()), 32'h0);
        check_val("mid_rst_count", instr_count, 32'h0);
        check_val("mid_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_val("mid_resume", 32'(strobes()), 32'h01);

        // num_of_ope=0 at P3: illegal_op and HALT, no clock_4.
        num_of_ope = 4'd0;
        tick();
        check_val("ill_p2", 32'(strobes()), 32'h02);
        tick();
        check_val("ill_p3", 32'(strobes()), 32'h04);
        repeat (3) begin
            tick();
            check_val("ill_halted", 32'(halted), 32'h1);
            check_val("ill_flag", 32'(illegal_op), 32'h1);
            check_val("ill_strobe", 32'(strobes()), 32'h0);
        end
        check_val("ill_count", instr_count, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
